light_decoder: RTL and testbench

- Receive-side counterpart of the colour-to-RGB path. Watches a 24-bit RGB light bus and recovers the 3-bit colour code behind it.
- Reports a code only after the bus has held the same legal value for a set number of cycles.
- Flags illegal pixel values, pulses on every confirmed colour change, and counts changes.
- Sits downstream of the light selector output for self-check and monitoring.

---
 rtl/light_decoder_if.sv | 26 ++
 rtl/light_decoder.sv | 137 +++++++++++++
 tb/tb_light_decoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/light_decoder_if.sv
// Bundle between an RGB light bus monitor and the light_decoder.
// The master drives the 24-bit light bus; the slave returns the locked colour and status.
interface light_decoder_if #(
  parameter int COUNT_WIDTH = 8
);
  logic [23:0]            light;
  logic [2:0]             colour;
  logic                   valid;
  logic                   white;
  logic                   err;
  logic                   change;
  logic [COUNT_WIDTH-1:0] change_count;
  logic                   dbg_locked;

  // No ready path: light is sampled unconditionally on every edge. valid qualifies
  // colour and white. change is a one-cycle pulse and must be observed every cycle.
  modport master (
    output light,
    input  colour, valid, white, err, change, change_count, dbg_locked
  );

  modport slave (
    input  light,
    output colour, valid, white, err, change, change_count, dbg_locked
  );
endinterface

// File: rtl/light_decoder.sv
// Recovers the 3-bit colour code from a registered RGB bus once it has been stable.
// Optional macro LIGHT_DECODER_TOLERANT_EN: each byte decodes by its MSB and no sample is illegal.
module light_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic            clk,
  input  logic            rst,
  light_decoder_if.slave  bus
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [23:0]            light_q;
  logic                   smp_vld_q;
  logic [2:0]             cand_q, cand_d;
  logic [7:0]             cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic [2:0]             colour_q, colour_d;
  logic                   valid_q, valid_d;
  logic                   white_q, white_d;
  logic                   err_q, err_d;
  logic                   change_q, change_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [2:0]             prev_q, prev_d;
  logic                   prev_vld_q, prev_vld_d;

  logic                   legal;
  logic [2:0]             code;

  always_comb begin
    code = {light_q[23], light_q[15], light_q[7]};
`ifdef LIGHT_DECODER_TOLERANT_EN
    legal = 1'b1;
`else
    legal = ((light_q[23:16] == 8'h00) || (light_q[23:16] == 8'hFF)) &&
            ((light_q[15:8]  == 8'h00) || (light_q[15:8]  == 8'hFF)) &&
            ((light_q[7:0]   == 8'h00) || (light_q[7:0]   == 8'hFF));
`endif
  end

  // smp_vld_q keeps the reset-cleared light_q from counting as a real sample.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (smp_vld_q) begin
      if (!legal) begin
        cnt_d = 8'd0;
        err_d = 1'b1;
      end else if ((code == cand_q) && (cnt_q != 8'd0)) begin
        cnt_d = (cnt_q < STABLE_C) ? cnt_q + 8'd1 : cnt_q;
      end else begin
        cand_d = code;
        cnt_d  = 8'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    colour_d   = colour_q;
    valid_d    = valid_q;
    white_d    = white_q;
    change_d   = 1'b0;
    count_d    = count_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    unique case (state_q)
      SEARCH: begin
        if (smp_vld_q && legal && (cnt_d == STABLE_C)) begin
          state_d    = LOCKED;
          valid_d    = 1'b1;
          colour_d   = cand_d;
          white_d    = (cand_d == 3'b111);
          prev_d     = cand_d;
          prev_vld_d = 1'b1;
          if (prev_vld_q && (prev_q != cand_d)) begin
            change_d = 1'b1;
            count_d  = count_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (smp_vld_q && (!legal || (code != colour_q))) begin
          state_d = SEARCH;
          valid_d = 1'b0;
          white_d = 1'b0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      light_q    <= 24'h000000;
      smp_vld_q  <= 1'b0;
      cand_q     <= 3'b000;
      cnt_q      <= 8'd0;
      state_q    <= SEARCH;
      colour_q   <= 3'b000;
      valid_q    <= 1'b0;
      white_q    <= 1'b0;
      err_q      <= 1'b0;
      change_q   <= 1'b0;
      count_q    <= '0;
      prev_q     <= 3'b000;
      prev_vld_q <= 1'b0;
    end else begin
      light_q    <= bus.light;
      smp_vld_q  <= 1'b1;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      colour_q   <= colour_d;
      valid_q    <= valid_d;
      white_q    <= white_d;
      err_q      <= err_d;
      change_q   <= change_d;
      count_q    <= count_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign bus.colour       = colour_q;
  assign bus.valid        = valid_q;
  assign bus.white        = white_q;
  assign bus.err          = err_q;
  assign bus.change       = change_q;
  assign bus.change_count = count_q;
  assign bus.dbg_locked   = (state_q == LOCKED);

endmodule

// File: tb/tb_light_decoder.sv
// Randomized bench for light_decoder against a run-length reference model of the light bus.
module tb_light_decoder;

  localparam int STABLE = 4;
  localparam int CW     = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  light_decoder_if #(.COUNT_WIDTH(CW)) bus ();

  light_decoder #(.STABLE_CYCLES(STABLE), .COUNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [23:0]   m_lq;
  bit            m_lq_vld;
  int            hist[$];
  bit            m_locked;
  logic [2:0]    m_colour;
  bit            m_white;
  bit            m_err;
  bit            m_change;
  logic [CW-1:0] m_count;
  bit            m_prev_vld;
  logic [2:0]    m_prev;

  // Returns the colour code of a bus value, or -1 when the value is illegal.
  function automatic int decode(input logic [23:0] v);
    int r;
    logic [7:0] b;
    r = 0;
    for (int i = 2; i >= 0; i--) begin
      b = v[i*8 +: 8];
`ifdef LIGHT_DECODER_TOLERANT_EN
      r = r * 2 + ((b >= 8'h80) ? 1 : 0);
`else
      if (b == 8'h00)      r = r * 2;
      else if (b == 8'hFF) r = r * 2 + 1;
      else                 return -1;
`endif
    end
    return r;
  endfunction

  task automatic model_edge(input logic [23:0] lt, input bit r);
    int c;
    int run;
    if (r) begin
      m_lq = 24'h0; m_lq_vld = 0; hist.delete();
      m_locked = 0; m_colour = 3'b000; m_white = 0; m_err = 0; m_change = 0;
      m_count = '0; m_prev_vld = 0; m_prev = 3'b000;
      return;
    end
    m_change = 0;
    if (m_lq_vld) begin
      c = decode(m_lq);
      hist.push_back(c);
      if (hist.size() > 32) void'(hist.pop_front());
      m_err = (c < 0);
      run = 0;
      if (c >= 0)
        for (int i = hist.size() - 1; i >= 0 && hist[i] == c; i--) run++;
      if (!m_locked) begin
        if (c >= 0 && run >= STABLE) begin
          m_locked = 1;
          m_colour = 3'(c);
          m_white  = (c == 7);
          if (m_prev_vld && m_prev != 3'(c)) begin
            m_change = 1;
            m_count  = m_count + 1'b1;
          end
          m_prev = 3'(c); m_prev_vld = 1;
        end
      end else if (c < 0 || 3'(c) != m_colour) begin
        m_locked = 0;
        m_white  = 0;
      end
    end else begin
      m_err = 0;
    end
    m_lq = lt; m_lq_vld = 1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check("valid",  32'(bus.valid),        32'(m_locked));
    check("colour", 32'(bus.colour),       32'(m_colour));
    check("white",  32'(bus.white),        32'(m_white));
    check("err",    32'(bus.err),          32'(m_err));
    check("change", 32'(bus.change),       32'(m_change));
    check("count",  32'(bus.change_count), 32'(m_count));
    check("locked", 32'(bus.dbg_locked),   32'(m_locked));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [23:0] lt, input bit r);
    bus.light = lt;
    rst       = r;
    @(posedge clk);
    model_edge(lt, r);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [23:0] lt, input int n);
    for (int i = 0; i < n; i++) step(lt, 1'b0);
  endtask

  function automatic logic [23:0] code_to_light(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] lt;
    int len;
    n_cmp = 0;
    n_bad = 0;
    bus.light = 24'h0;
    rst = 1'b1;
    model_edge(24'h0, 1'b1);

    step(24'h000000, 1'b1);
    step(24'h000000, 1'b1);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_count", 32'(bus.change_count), 32'd0);

    hold(24'h00FF00, 4);
    check("t1_not_yet", 32'(bus.valid), 32'd0);
    hold(24'h00FF00, 2);
    check("t1_colour", 32'(bus.colour), 32'd2);
    check("t1_valid",  32'(bus.valid),  32'd1);

    hold(24'hFF0000, 6);
    check("t2_colour", 32'(bus.colour), 32'd4);
    check("t2_count",  32'(bus.change_count), 32'd1);

    hold(24'h0000FF, 6);
    hold(24'hFFFF00, 2);
    hold(24'h0000FF, 6);
    check("t3_colour", 32'(bus.colour), 32'd1);
    check("t3_count",  32'(bus.change_count), 32'd2);

    hold(24'h80FF10, 4);
    hold(24'hFFFFFF, 6);
    check("t5_white", 32'(bus.white), 32'd1);

    step(24'hFFFFFF, 1'b1);
    check("t6_valid", 32'(bus.valid), 32'd0);
    check("t6_colour", 32'(bus.colour), 32'd0);
    hold(24'h00FFFF, 6);
    check("t6_colour_lock", 32'(bus.colour), 32'd3);
    check("t6_count", 32'(bus.change_count), 32'd0);

    for (int s = 0; s < 900; s++) begin
      if ($urandom_range(0, 99) < 15)
        lt = 24'($urandom());
      else
        lt = code_to_light(3'($urandom_range(0, 7)));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 199) == 0) step(lt, 1'b1);
      hold(lt, len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
